// File: rtl/axil_write_master.sv
// AXI4-Lite write master: command FIFO feeding independent AW/W issue, B tracking and response forwarding.
// Optional B-response watchdog enabled by defining AXIL_WM_TIMEOUT_EN.
module axil_write_master #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int CMD_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_data,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_resp,
  input  logic                  rsp_ready,
  output logic [3:0]            outstanding,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  logic [ADDR_W-1:0] mem_addr [CMD_DEPTH];
  logic [DATA_W-1:0] mem_data [CMD_DEPTH];
  logic [STRB_W-1:0] mem_strb [CMD_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, sel_ptr;
  logic [CNT_W-1:0]  count_q, remaining;
  state_t            state_q;
  logic              awvalid_q, wvalid_q, aw_done_q, w_done_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              rsp_valid_q;
  logic [1:0]        rsp_resp_q;
  logic [3:0]        outstanding_q, outstanding_d;

  logic              full, push, pop, aw_hs, w_hs, b_hs, retire;
  logic              use_byp, can_issue, load;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;
  logic [STRB_W-1:0] nxt_strb;

  assign full   = (count_q == CNT_W'(CMD_DEPTH));
  assign push   = cmd_valid && !full;
  assign aw_hs  = awvalid_q && awready;
  assign w_hs   = wvalid_q && wready;
  assign retire = (state_q == ISSUE) && (aw_done_q || aw_hs) && (w_done_q || w_hs);
  assign pop    = retire;
  assign bready = (outstanding_q != 4'd0) && (!rsp_valid_q || rsp_ready);
  assign b_hs   = bvalid && bready;

  always_comb begin
    outstanding_d = outstanding_q;
    if (retire && !b_hs)      outstanding_d = outstanding_q + 4'd1;
    else if (!retire && b_hs) outstanding_d = outstanding_q - 4'd1;
  end

  // The entry behind the current head (or the head itself when idle); an empty FIFO
  // forwards the command being pushed this cycle so issue starts one cycle after accept.
  assign remaining = (state_q == ISSUE) ? count_q - 1'b1 : count_q;
  assign sel_ptr   = (state_q == ISSUE) ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign use_byp   = (remaining == '0);
  assign nxt_addr  = use_byp ? cmd_addr : mem_addr[sel_ptr];
  assign nxt_data  = use_byp ? cmd_data : mem_data[sel_ptr];
  assign nxt_strb  = use_byp ? cmd_strb : mem_strb[sel_ptr];
  assign can_issue = (!use_byp || push) && (outstanding_d < 4'(MAX_OUTSTANDING));
  assign load      = can_issue && ((state_q == IDLE) || retire);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= cmd_addr;
      mem_data[wr_ptr_q] <= cmd_data;
      mem_strb[wr_ptr_q] <= cmd_strb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (load) begin
      state_q   <= ISSUE;
      awvalid_q <= 1'b1;
      wvalid_q  <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= nxt_addr;
      wdata_q   <= nxt_data;
      wstrb_q   <= nxt_strb;
    end else if (retire) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (state_q == ISSUE) begin
      if (aw_hs) begin
        awvalid_q <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        wvalid_q <= 1'b0;
        w_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_resp_q    <= 2'd0;
      outstanding_q <= 4'd0;
    end else begin
      outstanding_q <= outstanding_d;
      if (b_hs) begin
        rsp_valid_q <= 1'b1;
        rsp_resp_q  <= bresp;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef AXIL_WM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (outstanding_q == 4'd0 || b_hs)              tmo_cnt_d = '0;
    else if (tmo_cnt_q != TMO_W'(TIMEOUT_CYCLES))   tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (tmo_cnt_d == TMO_W'(TIMEOUT_CYCLES)) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign cmd_ready   = !full;
  assign awvalid     = awvalid_q;
  assign awaddr      = awaddr_q;
  assign wvalid      = wvalid_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_resp    = rsp_resp_q;
  assign outstanding = outstanding_q;
  assign busy        = (count_q != '0) || awvalid_q || wvalid_q || (outstanding_q != 4'd0);

endmodule

// File: tb/tb_axil_write_master.sv
// Bench for axil_write_master: directed table of single writes, multi-cycle corner sequences,
// then randomized traffic checked against a transaction-level scoreboard.
`define CHK(NM, ACT, EXP) chk(NM, 64'(ACT), 64'(EXP))
module tb_axil_write_master;

  localparam int CMD_DEPTH = 4;
  localparam int MAX_OUT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_strb;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rsp_resp;
  logic        bvalid, bready, rsp_valid, rsp_ready;
  logic [3:0]  outstanding;
  logic        busy, timeout_err;

  axil_write_master #(
    .ADDR_W(32), .DATA_W(32), .CMD_DEPTH(CMD_DEPTH),
    .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_ready(rsp_ready),
    .outstanding(outstanding), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  bresp;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl[4];
  int   n_vec = 0;
  int   n_err = 0;

  // scoreboard state for the randomized phase
  logic [31:0] q_addr[$];
  logic [35:0] q_wd[$];
  logic [31:0] aw_log[$];
  logic [35:0] w_log[$];
  logic [1:0]  b_log[$];
  logic [1:0]  rsp_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_strb = s;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp, input int exp_out);
    logic hs;
    hs = 1'b0;
    bvalid = 1'b1; bresp = resp;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      hs = bready;
      cyc(1);
    end
    bvalid = 1'b0;
    `CHK("b_handshake", hs, 1'b1);
    @(negedge clk);
    `CHK("rsp_valid", rsp_valid, 1'b1);
    `CHK("rsp_resp", rsp_resp, resp);
    `CHK("outstanding_after_b", outstanding, exp_out);
    cyc(1);
  endtask

  task automatic single_write(input vec_t v);
    logic aw_seen, w_seen;
    int   c;
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_data = v.data; cmd_strb = v.strb;
    @(negedge clk);
    `CHK("cmd_ready_idle", cmd_ready, 1'b1);
    `CHK("aw_not_yet", awvalid, 1'b0);
    cyc(1);
    cmd_valid = 1'b0;
    aw_seen = 1'b0; w_seen = 1'b0; c = 0;
    while (!(aw_seen && w_seen) && c < 20) begin
      awready = !aw_seen && (c >= v.aw_dly);
      wready  = !w_seen && (c >= v.w_dly);
      @(negedge clk);
      if (aw_seen) `CHK("aw_dropped", awvalid, 1'b0);
      else begin
        `CHK("aw_valid", awvalid, 1'b1);
        `CHK("awaddr", awaddr, v.addr);
      end
      if (w_seen) `CHK("w_dropped", wvalid, 1'b0);
      else begin
        `CHK("w_valid", wvalid, 1'b1);
        `CHK("wdata", wdata, v.data);
        `CHK("wstrb", wstrb, v.strb);
      end
      if (awready) aw_seen = 1'b1;
      if (wready)  w_seen  = 1'b1;
      cyc(1);
      c++;
    end
    awready = 1'b0; wready = 1'b0;
    `CHK("aw_w_handshakes", aw_seen && w_seen, 1'b1);
    @(negedge clk);
    `CHK("outstanding_one", outstanding, 1);
    `CHK("aw_idle_after", awvalid, 1'b0);
    `CHK("w_idle_after", wvalid, 1'b0);
    cyc(1);
    repeat (v.b_dly) begin
      @(negedge clk);
      `CHK("outstanding_wait_b", outstanding, 1);
      cyc(1);
    end
    send_b(v.bresp, 0);
    @(negedge clk);
    `CHK("rsp_consumed", rsp_valid, 1'b0);
    `CHK("busy_idle", busy, 1'b0);
    cyc(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic exp_to;
    int   push_cnt, aw_cnt, w_cnt, b_cnt, rsp_cnt, retired, pushes_left;
    logic cmd_acc, b_acc, aw_pend, w_pend, done;
    logic [31:0] aw_prev;
    logic [35:0] w_prev;

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0; rsp_ready = 1'b1;

    tbl[0] = '{32'h0000_1000, 32'h1234_5678, 4'hF, 0, 0, 2, 2'd0, 2'd0};
    tbl[1] = '{32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 0, 3, 1, 2'd2, 2'd2};
    tbl[2] = '{32'h0000_3004, 32'hA5A5_5A5A, 4'hC, 2, 0, 0, 2'd1, 2'd1};
    tbl[3] = '{32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 1, 1, 3, 2'd3, 2'd3};

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    `CHK("rst_awvalid", awvalid, 1'b0);
    `CHK("rst_wvalid", wvalid, 1'b0);
    `CHK("rst_rsp_valid", rsp_valid, 1'b0);
    `CHK("rst_timeout_err", timeout_err, 1'b0);
    `CHK("rst_busy", busy, 1'b0);
    `CHK("rst_outstanding", outstanding, 0);
    `CHK("rst_payload", {awaddr, wdata, wstrb, rsp_resp}, 70'd0);
    `CHK("rst_cmd_ready", cmd_ready, 1'b1);
    `CHK("rst_bready", bready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1);

    // single writes with assorted slave timing
    for (int i = 0; i < 4; i++) single_write(tbl[i]);

    // stray B with nothing outstanding is ignored
    bvalid = 1'b1; bresp = 2'd2;
    repeat (3) begin
      @(negedge clk);
      `CHK("stray_b_bready", bready, 1'b0);
      `CHK("stray_b_rsp", rsp_valid, 1'b0);
      `CHK("stray_b_out", outstanding, 0);
      cyc(1);
    end
    bvalid = 1'b0;

    // back-to-back issue and the outstanding cap
    awready = 1'b1; wready = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(32'h1000 + 32'(4 * i), 32'(i), 4'hF);
    cyc(4);
    @(negedge clk);
    `CHK("b2b_outstanding3", outstanding, 3);
    `CHK("b2b_aw_idle", awvalid, 1'b0);
    cyc(1);
    push_cmd(32'h100C, 32'd3, 4'hF);
    push_cmd(32'h1010, 32'd4, 4'hF);
    cyc(4);
    @(negedge clk);
    `CHK("cap_outstanding", outstanding, MAX_OUT);
    `CHK("cap_no_issue", awvalid, 1'b0);
    `CHK("cap_busy", busy, 1'b1);
    cyc(1);
    send_b(2'd2, MAX_OUT - 1);
    cyc(3);
    @(negedge clk);
    `CHK("cap_released", outstanding, MAX_OUT);
    cyc(1);
    for (int i = 0; i < MAX_OUT; i++) send_b(2'd0, MAX_OUT - 1 - i);
    @(negedge clk);
    `CHK("b2b_drained_busy", busy, 1'b0);
    cyc(1);

    // fill the FIFO with the slave stalled
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < CMD_DEPTH; i++) begin
      cmd_valid = 1'b1; cmd_addr = 32'h2000 + 32'(4 * i); cmd_data = 32'(i); cmd_strb = 4'h1;
      @(negedge clk);
      `CHK("fill_cmd_ready", cmd_ready, 1'b1);
      cyc(1);
    end
    cmd_addr = 32'h2FFF_0000;
    repeat (3) begin
      @(negedge clk);
      `CHK("full_cmd_ready", cmd_ready, 1'b0);
      `CHK("full_awaddr_head", awaddr, 32'h2000);
      cyc(1);
    end
    cmd_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    cyc(8);
    @(negedge clk);
    `CHK("drain_outstanding", outstanding, CMD_DEPTH);
    `CHK("drain_cmd_ready", cmd_ready, 1'b1);
    `CHK("drain_aw_idle", awvalid, 1'b0);
    cyc(1);
    for (int i = 0; i < CMD_DEPTH; i++) send_b(2'd0, CMD_DEPTH - 1 - i);
    cyc(3);
    @(negedge clk);
    `CHK("drain_exactly_four", awvalid, 1'b0);
    `CHK("drain_busy", busy, 1'b0);
    cyc(1);

    // B-response watchdog
`ifdef AXIL_WM_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    push_cmd(32'h4000, 32'h55, 4'hF);
    cyc(6);
    @(negedge clk);
    `CHK("timeout_early", timeout_err, 1'b0);
    cyc(14);
    @(negedge clk);
    `CHK("timeout_late", timeout_err, exp_to);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    `CHK("timeout_cleared", timeout_err, 1'b0);
    `CHK("timeout_rst_out", outstanding, 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // asynchronous reset in the middle of issue with a response pending
    push_cmd(32'h5000, 32'h1, 4'hF);
    push_cmd(32'h5004, 32'h2, 4'hF);
    cyc(3);
    rsp_ready = 1'b0;
    send_b(2'd1, 1);
    awready = 1'b0; wready = 1'b0;
    push_cmd(32'h5008, 32'h3, 4'hF);
    @(negedge clk);
    `CHK("pre_rst_awvalid", awvalid, 1'b1);
    `CHK("pre_rst_rsp_valid", rsp_valid, 1'b1);
    `CHK("pre_rst_outstanding", outstanding, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    `CHK("async_rst_awvalid", awvalid, 1'b0);
    `CHK("async_rst_wvalid", wvalid, 1'b0);
    `CHK("async_rst_rsp_valid", rsp_valid, 1'b0);
    `CHK("async_rst_outstanding", outstanding, 0);
    `CHK("async_rst_cmd_ready", cmd_ready, 1'b1);
    `CHK("async_rst_busy", busy, 1'b0);
    cyc(1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    cyc(1);

    // randomized traffic against a transaction-level scoreboard
    push_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; rsp_cnt = 0;
    cmd_acc = 1'b0; b_acc = 1'b0; aw_pend = 1'b0; w_pend = 1'b0; done = 1'b0;
    aw_prev = '0; w_prev = '0;
    pushes_left = 150;
    for (int k = 0; k < 4000 && !done; k++) begin
      if (!cmd_valid || cmd_acc) begin
        if (pushes_left > 0 && $urandom_range(0, 3) != 0) begin
          cmd_valid = 1'b1; cmd_addr = $urandom; cmd_data = $urandom; cmd_strb = 4'($urandom);
          pushes_left--;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      awready   = ($urandom_range(0, 2) != 0);
      wready    = ($urandom_range(0, 2) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!bvalid || b_acc) begin
        bvalid = 1'($urandom_range(0, 1));
        bresp  = 2'($urandom);
      end
      @(negedge clk);
      retired = (aw_cnt < w_cnt) ? aw_cnt : w_cnt;
      n_vec++;
      if (64'(outstanding) !== 64'(retired - b_cnt)) begin
        n_err++;
        $display("FAIL rnd_outstanding: got %0h expected %0h", outstanding, retired - b_cnt);
      end
      n_vec++;
      if (cmd_ready !== ((push_cnt - retired) < CMD_DEPTH)) begin
        n_err++;
        $display("FAIL rnd_cmd_ready: got %0h expected %0h", cmd_ready,
                 (push_cnt - retired) < CMD_DEPTH);
      end
      n_vec++;
      if (busy !== (((push_cnt - retired) != 0) || ((retired - b_cnt) != 0))) begin
        n_err++;
        $display("FAIL rnd_busy: got %0h", busy);
      end
      n_vec++;
      if (rsp_valid !== ((b_cnt - rsp_cnt) != 0)) begin
        n_err++;
        $display("FAIL rnd_rsp_valid: got %0h", rsp_valid);
      end
      n_vec++;
      if (bready !== (((retired - b_cnt) != 0) && (!rsp_valid || rsp_ready))) begin
        n_err++;
        $display("FAIL rnd_bready: got %0h", bready);
      end
      if (aw_pend) `CHK("rnd_aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
      if (w_pend)  `CHK("rnd_w_stable", {wvalid, wdata, wstrb}, {1'b1, w_prev});
      cmd_acc = cmd_valid && cmd_ready;
      b_acc   = bvalid && bready;
      if (cmd_acc) begin
        q_addr.push_back(cmd_addr);
        q_wd.push_back({cmd_data, cmd_strb});
        push_cnt++;
      end
      if (awvalid && awready) begin aw_log.push_back(awaddr); aw_cnt++; end
      if (wvalid && wready)   begin w_log.push_back({wdata, wstrb}); w_cnt++; end
      if (b_acc) begin b_log.push_back(bresp); b_cnt++; end
      if (rsp_valid && rsp_ready) begin rsp_log.push_back(rsp_resp); rsp_cnt++; end
      aw_pend = awvalid && !awready;
      aw_prev = awaddr;
      w_pend  = wvalid && !wready;
      w_prev  = {wdata, wstrb};
      done = (pushes_left == 0) && (cmd_acc || !cmd_valid) &&
             (b_cnt == push_cnt) && (rsp_cnt == b_cnt);
      cyc(1);
    end
    cmd_valid = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0; rsp_ready = 1'b1;
    `CHK("rnd_drained", done, 1'b1);
    `CHK("rnd_aw_count", aw_log.size(), q_addr.size());
    `CHK("rnd_w_count", w_log.size(), q_wd.size());
    `CHK("rnd_rsp_count", rsp_log.size(), b_log.size());
    for (int i = 0; i < q_addr.size() && i < aw_log.size(); i++)
      `CHK("rnd_aw_order", aw_log[i], q_addr[i]);
    for (int i = 0; i < q_wd.size() && i < w_log.size(); i++)
      `CHK("rnd_w_order", w_log[i], q_wd[i]);
    for (int i = 0; i < b_log.size() && i < rsp_log.size(); i++)
      `CHK("rnd_rsp_order", rsp_log[i], b_log[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
